rv_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M operation set (XLEN-generic) for the pipelined core. It sits in the EX stage beside the ULA. It accepts one operation at a time from ID/EX and holds the pipeline through `busy` until `done`. It adds `enable` stall, `flush` abort and an optional single-cycle multiply mode.

---
 rtl/rv_pkg.sv | 36 +++
 rtl/rv_div_step.sv | 22 ++
 rtl/rv_muldiv.sv | 177 +++++++++++++++++
 tb/tb_rv_muldiv.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared core definitions used by the M-extension multiply/divide unit.
package rv_pkg;

  // funct3 encodings of the RV32M operations
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  // Decode constants control uses to recognise an M-extension instruction
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADJ  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // rs1 is signed for MULH, MULHSU, DIV and REM
  function automatic logic mdu_a_signed(input logic [2:0] f3);
    return (f3 == MDU_MULH) || (f3 == MDU_MULHSU) ||
           (f3 == MDU_DIV)  || (f3 == MDU_REM);
  endfunction

  // rs2 is signed for MULH, DIV and REM (MULHSU keeps it unsigned)
  function automatic logic mdu_b_signed(input logic [2:0] f3);
    return (f3 == MDU_MULH) || (f3 == MDU_DIV) || (f3 == MDU_REM);
  endfunction

endpackage

// File: rtl/rv_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module rv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] trial;

  // The true difference is always below the divisor, so XLEN bits suffice
  always_comb begin
    trial   = {rem_in, bit_in};
    q_bit   = (trial >= {1'b0, divisor});
    rem_out = q_bit ? (trial[XLEN-1:0] - divisor) : trial[XLEN-1:0];
  end

endmodule

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage. Works on operand
// magnitudes and fixes the signs in a final ADJ cycle; divide-by-zero, signed
// overflow and (optionally) multiplies complete directly at the accept edge.
import rv_pkg::*;

module rv_muldiv #(
  parameter int XLEN     = 32,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state;
  logic [CW-1:0]     cnt;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mb;      // multiplicand or divisor magnitude
  logic [2:0]        f3_q;
  logic              neg_a;
  logic              neg_b;
  logic [4:0]        rd_q;

  // Accept-path decode
  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] ext_a;
  logic [2*XLEN-1:0] ext_b;
  logic [2*XLEN-1:0] fast_prod;
  logic              div_zero;
  logic              div_ovf;
  logic              is_fast;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   fast_res;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_rem;
  logic              div_q;

  // Sign correction
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   adj_res;

  // Decode the incoming request: magnitudes, sign flags, shortcut results
  always_comb begin
    a_sgn     = mdu_a_signed(funct3);
    b_sgn     = mdu_b_signed(funct3);
    a_neg     = a_sgn & op_a[XLEN-1];
    b_neg     = b_sgn & op_b[XLEN-1];
    mag_a     = a_neg ? -op_a : op_a;
    mag_b     = b_neg ? -op_b : op_b;
    ext_a     = a_sgn ? {{XLEN{op_a[XLEN-1]}}, op_a} : {{XLEN{1'b0}}, op_a};
    ext_b     = b_sgn ? {{XLEN{op_b[XLEN-1]}}, op_b} : {{XLEN{1'b0}}, op_b};
    fast_prod = ext_a * ext_b;
    fast_res  = (funct3 == MDU_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    is_fast   = MUL_FAST && !funct3[2];
    div_zero  = funct3[2] && (op_b == '0);
    div_ovf   = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
                (op_a == MOST_NEG) && (op_b == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = funct3[1] ? op_a : '1;
    else          special_res = funct3[1] ? '0 : MOST_NEG;
  end

  // Shift-add multiply step: conditionally add the multiplicand, shift right
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mb};
    mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    div_next = {div_rem, acc[XLEN-2:0], div_q};
  end

  rv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (acc[2*XLEN-1:XLEN]),
    .bit_in  (acc[XLEN-1]),
    .divisor (mb),
    .rem_out (div_rem),
    .q_bit   (div_q)
  );

  // Apply operand signs to the unsigned product / quotient / remainder
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quo_fix  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3_q)
      MDU_MUL:                         adj_res = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: adj_res = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               adj_res = quo_fix;
      default:                         adj_res = rem_fix;
    endcase
  end

  // Control FSM with registered busy/done/result/rd_out; flush beats start and enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mb     <= '0;
      f3_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      rd_q   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            f3_q  <= funct3;
            rd_q  <= rd_in;
            neg_a <= a_neg;
            neg_b <= b_neg;
            mb    <= mag_b;
            if (div_zero || div_ovf || is_fast) begin
              result <= (div_zero || div_ovf) ? special_res : fast_res;
              rd_out <= rd_in;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, mag_a};
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= f3_q[2] ? div_next : mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) state <= ADJ;
        end
        ADJ: begin
          result <= adj_res;
          rd_out <= rd_q;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_muldiv.sv
// Bench for rv_muldiv: an iterative and a fast-multiply instance share the
// stimulus; an arithmetic reference model tracks what each must output.
import rv_pkg::*;

module tb_rv_muldiv;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, enable, flush, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic [1:0]  busy, done;
  logic [31:0] result [2];
  logic [4:0]  rd_out [2];

  int nvec = 0;
  int nerr = 0;

  logic        f_done;
  logic [31:0] f_res;

  always #5 clk = ~clk;

  rv_muldiv #(.XLEN(XLEN), .MUL_FAST(1'b0)) dut_iter (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .start(start),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy[0]), .done(done[0]), .result(result[0]), .rd_out(rd_out[0]));

  rv_muldiv #(.XLEN(XLEN), .MUL_FAST(1'b1)) dut_fast (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .start(start),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy[1]), .done(done[1]), .result(result[1]), .rd_out(rd_out[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // RV32M result from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      MDU_MUL:    begin p = sa * sb; return p[31:0]; end
      MDU_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MDU_MULHU:  begin p = ua * ub; return p[63:32]; end
      MDU_DIV:    return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
      MDU_DIVU:   return (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
      MDU_REM:    return (b == 0) ? a : 32'(sa % sb);
      default:    return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  // Enabled edges after the accept edge until done shows (0: done right after accept)
  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit fast);
    bit special;
    special = f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    return (special || (fast && !f[2])) ? 0 : XLEN + 1;
  endfunction

  // Compare process: advance the model one edge, then check both instances
  bit          m_busy [2], m_done [2], m_pend [2];
  logic [31:0] m_res [2], p_res [2];
  logic [4:0]  m_rd [2], p_rd [2];
  int          m_age [2], m_lat [2];

  initial begin
    bit took;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_pend[i] = 0;
      m_res[i] = '0; m_rd[i] = '0; m_age[i] = 0; m_lat[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_pend[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_res[i] = '0; m_rd[i] = '0;
        end else begin
          took = !m_busy[i] && start && enable && !flush;
          if (flush) begin
            m_pend[i] = 0; m_busy[i] = 0; m_done[i] = 0;
          end else if (enable) begin
            m_done[i] = 0;
            if (m_pend[i]) begin
              m_age[i]++;
              if (m_age[i] == m_lat[i]) begin
                m_done[i] = 1; m_busy[i] = 0; m_pend[i] = 0;
                m_res[i] = p_res[i]; m_rd[i] = p_rd[i];
              end
            end
            if (took) begin
              p_res[i] = model(funct3, op_a, op_b);
              p_rd[i]  = rd_in;
              m_lat[i] = lat_of(funct3, op_a, op_b, i == 1);
              m_age[i] = 0;
              if (m_lat[i] == 0) begin
                m_done[i] = 1; m_res[i] = p_res[i]; m_rd[i] = p_rd[i];
              end else begin
                m_pend[i] = 1; m_busy[i] = 1;
              end
            end
          end
        end
        chk1($sformatf("dut%0d busy", i), busy[i], m_busy[i]);
        chk1($sformatf("dut%0d done", i), done[i], m_done[i]);
        chk($sformatf("dut%0d result", i), result[i], m_res[i]);
        chk($sformatf("dut%0d rd_out", i), 32'(rd_out[i]), 32'(m_rd[i]));
      end
    end
  end

  // Issue one operation, wait for the iterative instance, check literal expectations
  task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] r, input logic [31:0] exp, input int exp_n,
                    input bit b2b, input bit chk_fast);
    int n;
    if (!b2b) @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = r;
    @(negedge clk);
    start = 1'b0;
    f_done = done[1];
    f_res  = result[1];
    n = 0;
    while (!done[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("op f3=%0d result", f), result[0], exp);
    chk($sformatf("op f3=%0d rd_out", f), 32'(rd_out[0]), 32'(r));
    chk($sformatf("op f3=%0d latency", f), n, exp_n);
    if (exp_n == 0) chk1("special busy", busy[0], 1'b0);
    if (chk_fast) begin
      chk1($sformatf("fast f3=%0d done", f), f_done, 1'b1);
      chk($sformatf("fast f3=%0d result", f), f_res, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b1; flush = 1'b0; start = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    chk1("reset busy", busy[0], 1'b0);
    chk1("reset done", done[0], 1'b0);
    chk("reset result", result[0], 32'h0);
    rst = 1'b0;

    // Multiplies
    op(MDU_MUL,    32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33, 0, 1);
    op(MDU_MULH,   32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 33, 0, 1);
    op(MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 33, 0, 1);
    op(MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 33, 0, 1);
    op(MDU_MULH,   32'hFFFFFFFE, 32'd3,        5'd5, 32'hFFFFFFFF, 33, 0, 1);
    op(MDU_MUL,    32'h12345678, 32'h10,       5'd6, 32'h23456780, 33, 0, 1);
    op(MDU_MULHSU, 32'h80000000, 32'd2,        5'd7, 32'hFFFFFFFF, 33, 0, 1);

    // Divides, second one accepted back-to-back in DONE
    op(MDU_DIV,  32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFD, 33, 0, 0);
    op(MDU_REM,  32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, 33, 1, 0);
    op(MDU_DIV,  32'd100,      32'hFFFFFFF9, 5'd10, 32'hFFFFFFF2, 33, 0, 0);
    op(MDU_REM,  32'd100,      32'hFFFFFFF9, 5'd11, 32'd2,        33, 0, 0);
    op(MDU_DIVU, 32'hFFFFFFFF, 32'd10,       5'd12, 32'h19999999, 33, 0, 0);
    op(MDU_REMU, 32'hFFFFFFFF, 32'd10,       5'd13, 32'd5,        33, 0, 0);

    // Special cases complete at the accept edge
    op(MDU_REMU, 32'd5,        32'd0,        5'd14, 32'd5,        0, 0, 0);
    op(MDU_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 0, 0, 0);
    op(MDU_REM,  32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h0,        0, 0, 0);
    op(MDU_DIVU, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 0, 0, 0);

    // Flush ten cycles into a divide: no done, result and tag keep old values
    @(negedge clk);
    start = 1'b1; funct3 = MDU_DIV; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd18;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk1("flush busy", busy[0], 1'b0);
    chk1("flush done", done[0], 1'b0);
    chk("flush result", result[0], 32'hFFFFFFFF);
    chk("flush rd_out", 32'(rd_out[0]), 32'd17);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0]) n++;
    end
    chk("flush no done", n, 0);

    // Five stalled cycles mid-divide push completion out by five edges
    @(negedge clk);
    start = 1'b1; funct3 = MDU_DIVU; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd19;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done[0] && n < 100) begin
      if (n == 10) enable = 1'b0;
      if (n == 15) enable = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("stall latency", n, 38);
    chk("stall result", result[0], 32'd142);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk1("done stretched", done[0], 1'b1);
    enable = 1'b1;
    @(negedge clk);
    chk1("done after stretch", done[0], 1'b0);

    // Asynchronous reset mid-operation, then a normal operation
    @(negedge clk);
    start = 1'b1; funct3 = MDU_MULHU; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; rd_in = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("async rst busy", busy[0], 1'b0);
    chk1("async rst done", done[0], 1'b0);
    chk("async rst result", result[0], 32'h0);
    chk("async rst rd_out", 32'(rd_out[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    op(MDU_MUL, 32'd3, 32'd5, 5'd21, 32'd15, 33, 0, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
